// File: rtl/ovo_svm_pkg.sv
// Shared widths, pair-index lookup and per-dataset classifier constants
// for the one-vs-one SVM sequencer.
package ovo_svm_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, ARGMAX, DONE} state_e;

  localparam int DS_DEMO     = 0;
  localparam int DS_BIAS_POS = 1;
  localparam int DS_BIAS_NEG = 2;
  localparam int DS_BIAS_ALT = 3;

  localparam int DEMO_B [3] = '{-10, 5, 0};

  // max(1, clog2(n)) so single-entry tables still get a 1-bit index
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int n_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Member 0 (i) or 1 (j) of pair k under lexicographic (i,j), i<j ordering
  function automatic int pair_member(input int n, input int k, input bit second);
    int idx;
    int res;
    idx = 0;
    res = 0;
    for (int i = 0; i < n - 1; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (idx == k) res = second ? j : i;
        idx++;
      end
    end
    return res;
  endfunction

  function automatic int weight_of(input int ds, input int k, input int f);
    if (ds != DS_DEMO) return 0;
    case (k)
      0:       return (f == 0 || f == 1) ? 1 : 0;
      1:       return (f == 2) ? -3 : ((f == 20) ? 2 : 0);
      2:       return (f == 5) ? -128 : ((f == 6) ? 127 : 0);
      default: return 0;
    endcase
  endfunction

  function automatic int bias_of(input int ds, input int k);
    case (ds)
      DS_DEMO:     return (k < 3) ? DEMO_B[k] : 0;
      DS_BIAS_POS: return 1;
      DS_BIAS_NEG: return -1;
      DS_BIAS_ALT: return (k % 2 == 0) ? 1 : -1;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/ovo_svm_sequencer_if.sv
// Feature-in / class-out handshake bundle of the OvO SVM sequencer.
interface ovo_svm_sequencer_if
  import ovo_svm_pkg::*;
#(
  parameter int N_CLASSES  = 3,
  parameter int N_FEATURES = 21,
  parameter int INPUT_W    = 4
) ();
  localparam int CLS_W = idx_w(N_CLASSES);

  logic [N_FEATURES*INPUT_W-1:0] in;
  logic                          in_valid;
  logic                          in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [CLS_W-1:0]              w_class;

  modport master (output in, in_valid, out_ready, input in_ready, out_valid, w_class);
  modport slave  (input in, in_valid, out_ready, output in_ready, out_valid, w_class);
endinterface

// File: rtl/svm_pair_eval.sv
// Combinational dot product plus bias for one pairwise classifier;
// decision is 1 when the score is non-negative.
module svm_pair_eval #(
  parameter int N_FEATURES = 21,
  parameter int INPUT_W    = 4,
  parameter int WEIGHT_W   = 8,
  parameter int BIAS_W     = 12
) (
  input  logic [N_FEATURES*INPUT_W-1:0]  features,
  input  logic [N_FEATURES*WEIGHT_W-1:0] weights,
  input  logic signed [BIAS_W-1:0]       bias,
  output logic                           decision
);
  localparam int ACC_W = INPUT_W + WEIGHT_W + $clog2(N_FEATURES) + 2;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] x_ext;

  always_comb begin
    acc   = ACC_W'(bias);
    w_ext = '0;
    x_ext = '0;
    for (int f = 0; f < N_FEATURES; f++) begin
      w_ext = ACC_W'($signed(weights[f*WEIGHT_W +: WEIGHT_W]));
      // features are unsigned: zero-extend before the signed multiply
      x_ext = ACC_W'(features[f*INPUT_W +: INPUT_W]);
      acc   = acc + w_ext * x_ext;
    end
  end

  assign decision = ~acc[ACC_W-1];
endmodule

// File: rtl/ovo_svm_sequencer.sv
// One-vs-one SVM classifier: evaluates all class pairs one per cycle on a
// shared evaluator, tallies votes and reports the argmax class.
//
// state  | meaning
// IDLE   | waiting for a feature vector (in_ready high)
// EVAL   | scoring pair k, voting, advancing k
// ARGMAX | registering the class with the most votes
// DONE   | result valid, held until out_ready
module ovo_svm_sequencer
  import ovo_svm_pkg::*;
#(
  parameter int N_CLASSES  = 3,
  parameter int N_FEATURES = 21,
  parameter int INPUT_W    = 4,
  parameter int WEIGHT_W   = 8,
  parameter int BIAS_W     = 12,
  parameter int DATASET    = DS_DEMO
) (
  input logic               clk,
  input logic               rst_n,
  ovo_svm_sequencer_if.slave bus
);
  localparam int P      = n_pairs(N_CLASSES);
  localparam int CLS_W  = idx_w(N_CLASSES);
  localparam int VOTE_W = $clog2(N_CLASSES);
  localparam int K_W    = idx_w(P);

  function automatic logic [N_FEATURES*WEIGHT_W-1:0] weight_row(input int k);
    logic [N_FEATURES*WEIGHT_W-1:0] row;
    row = '0;
    for (int f = 0; f < N_FEATURES; f++)
      row[f*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(weight_of(DATASET, k, f));
    return row;
  endfunction

  logic [N_FEATURES*WEIGHT_W-1:0] w_rom [P];
  logic signed [BIAS_W-1:0]       b_rom [P];
  logic [CLS_W-1:0]               pair_i_tab [P];
  logic [CLS_W-1:0]               pair_j_tab [P];

  for (genvar g = 0; g < P; g++) begin : g_rom
    assign w_rom[g]      = weight_row(g);
    assign b_rom[g]      = BIAS_W'(bias_of(DATASET, g));
    assign pair_i_tab[g] = CLS_W'(pair_member(N_CLASSES, g, 1'b0));
    assign pair_j_tab[g] = CLS_W'(pair_member(N_CLASSES, g, 1'b1));
  end

  state_e                        state_q, state_d;
  logic [K_W-1:0]                k_q, k_d;
  logic [VOTE_W-1:0]             vote_q [N_CLASSES];
  logic [VOTE_W-1:0]             vote_d [N_CLASSES];
  logic [CLS_W-1:0]              w_class_q, w_class_d;
  logic [N_FEATURES*INPUT_W-1:0] feat_q, feat_d;
  logic [CLS_W-1:0]              best;
  logic                          decision;

  svm_pair_eval #(
    .N_FEATURES (N_FEATURES),
    .INPUT_W    (INPUT_W),
    .WEIGHT_W   (WEIGHT_W),
    .BIAS_W     (BIAS_W)
  ) u_eval (
    .features (feat_q),
    .weights  (w_rom[k_q]),
    .bias     (b_rom[k_q]),
    .decision (decision)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    vote_d    = vote_q;
    w_class_d = w_class_q;
    feat_d    = feat_q;
    best      = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          feat_d  = bus.in;
          vote_d  = '{default: '0};
          k_d     = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (decision) vote_d[pair_i_tab[k_q]] = vote_q[pair_i_tab[k_q]] + 1'b1;
        else          vote_d[pair_j_tab[k_q]] = vote_q[pair_j_tab[k_q]] + 1'b1;
        if (k_q == K_W'(P - 1)) begin
          k_d     = '0;
          state_d = ARGMAX;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ARGMAX: begin
        // strict compare keeps the lowest index on ties
        for (int c = 1; c < N_CLASSES; c++)
          if (vote_q[c] > vote_q[best]) best = CLS_W'(c);
        w_class_d = best;
        state_d   = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      vote_q    <= '{default: '0};
      w_class_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      vote_q    <= vote_d;
      w_class_q <= w_class_d;
    end
  end

  // Feature latch carries no reset; it is only read after an accept
  always_ff @(posedge clk) begin
    feat_q <= feat_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.w_class   = w_class_q;
endmodule

// File: tb/tb_ovo_svm_sequencer.sv
// Directed bench: several sequencer instances with different class counts
// and classifier constants, checked against hand-computed results.
module tb_ovo_svm_sequencer;
  import ovo_svm_pkg::*;

  localparam int ND = 5;
  localparam int NC [ND]   = '{3, 3, 3, 4, 3};
  localparam int DSET [ND] = '{DS_BIAS_POS, DS_BIAS_NEG, DS_BIAS_ALT, DS_BIAS_NEG, DS_DEMO};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [83:0]   in_vec;
  logic [ND-1:0] iv, ordy, ir, ov;
  logic [1:0]    wc [ND];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    ovo_svm_sequencer_if #(.N_CLASSES(NC[g]), .N_FEATURES(21), .INPUT_W(4)) bus ();
    assign bus.in        = in_vec;
    assign bus.in_valid  = iv[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign wc[g]         = bus.w_class;
    ovo_svm_sequencer #(
      .N_CLASSES(NC[g]), .N_FEATURES(21), .INPUT_W(4),
      .WEIGHT_W(8), .BIAS_W(12), .DATASET(DSET[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  // Features 0,1,2,5,6,20 carry the demo weights; the rest get filler 9
  function automatic logic [83:0] fv(input int a0, input int a1, input int a2,
                                     input int a5, input int a6, input int a20);
    logic [83:0] v;
    v = {21{4'h9}};
    v[0+:4]  = 4'(a0);
    v[4+:4]  = 4'(a1);
    v[8+:4]  = 4'(a2);
    v[20+:4] = 4'(a5);
    v[24+:4] = 4'(a6);
    v[80+:4] = 4'(a20);
    return v;
  endfunction

  // Accepts x on DUT d, scrambles `in` afterwards, counts edges to out_valid
  task automatic run_inference(input int d, input logic [83:0] x, input logic [1:0] exp_cls,
                               input int exp_lat, input string name);
    int cnt;
    @(negedge clk);
    n_checks++;
    if (ir[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, ir[d]);
    end
    in_vec = x;
    iv[d]  = 1'b1;
    @(posedge clk);
    #1;
    iv[d]  = 1'b0;
    in_vec = ~x;
    n_checks++;
    if (ir[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready_after_accept: got %b want 0", name, ir[d]);
    end
    cnt = 0;
    while (ov[d] !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_checks++;
    if (cnt !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges want %0d", name, cnt, exp_lat);
    end
    n_checks++;
    if (wc[d] !== exp_cls) begin
      n_fail++;
      $display("FAIL %s w_class: got %0d want %0d", name, wc[d], exp_cls);
    end
  endtask

  task automatic release_result(input int d, input string name);
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    n_checks++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, ov[d], ir[d]);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    iv     = '0;
    ordy   = '0;
    in_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || wc[d] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_dut%0d: got in_ready=%b out_valid=%b w_class=%0d want 1/0/0",
                 d, ir[d], ov[d], wc[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bias_pos();
    run_inference(0, fv(1, 2, 3, 4, 5, 6), 2'd0, 4, "bias_pos");
    n_checks++;
    if (g_dut[0].u_dut.vote_q[0] !== 2'd2 || g_dut[0].u_dut.vote_q[1] !== 2'd1 ||
        g_dut[0].u_dut.vote_q[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL bias_pos votes: got %0d,%0d,%0d want 2,1,0", g_dut[0].u_dut.vote_q[0],
               g_dut[0].u_dut.vote_q[1], g_dut[0].u_dut.vote_q[2]);
    end
    release_result(0, "bias_pos");
  endtask

  task automatic test_bias_neg();
    run_inference(1, fv(15, 15, 15, 15, 15, 15), 2'd2, 4, "bias_neg");
    n_checks++;
    if (g_dut[1].u_dut.vote_q[0] !== 2'd0 || g_dut[1].u_dut.vote_q[1] !== 2'd1 ||
        g_dut[1].u_dut.vote_q[2] !== 2'd2) begin
      n_fail++;
      $display("FAIL bias_neg votes: got %0d,%0d,%0d want 0,1,2", g_dut[1].u_dut.vote_q[0],
               g_dut[1].u_dut.vote_q[1], g_dut[1].u_dut.vote_q[2]);
    end
    release_result(1, "bias_neg");
  endtask

  task automatic test_tie();
    run_inference(2, fv(0, 0, 0, 0, 0, 0), 2'd0, 4, "tie");
    n_checks++;
    if (g_dut[2].u_dut.vote_q[0] !== 2'd1 || g_dut[2].u_dut.vote_q[1] !== 2'd1 ||
        g_dut[2].u_dut.vote_q[2] !== 2'd1) begin
      n_fail++;
      $display("FAIL tie votes: got %0d,%0d,%0d want 1,1,1", g_dut[2].u_dut.vote_q[0],
               g_dut[2].u_dut.vote_q[1], g_dut[2].u_dut.vote_q[2]);
    end
    release_result(2, "tie");
  endtask

  task automatic test_four_class();
    run_inference(3, fv(7, 7, 7, 7, 7, 7), 2'd3, 7, "four_class");
    n_checks++;
    if (g_dut[3].u_dut.vote_q[0] !== 2'd0 || g_dut[3].u_dut.vote_q[1] !== 2'd1 ||
        g_dut[3].u_dut.vote_q[2] !== 2'd2 || g_dut[3].u_dut.vote_q[3] !== 2'd3) begin
      n_fail++;
      $display("FAIL four_class votes: got %0d,%0d,%0d,%0d want 0,1,2,3",
               g_dut[3].u_dut.vote_q[0], g_dut[3].u_dut.vote_q[1],
               g_dut[3].u_dut.vote_q[2], g_dut[3].u_dut.vote_q[3]);
    end
    release_result(3, "four_class");
  endtask

  // Demo pairs: d0 = x0+x1-10, d1 = 5-3*x2+2*x20, d2 = 127*x6-128*x5
  task automatic test_dot_product();
    logic [83:0] vecs [7];
    logic [1:0]  want [7];
    vecs[0] = fv(15, 0, 0, 0, 0, 0);    want[0] = 2'd0;
    vecs[1] = fv(4, 5, 2, 1, 1, 0);     want[1] = 2'd2;
    vecs[2] = fv(5, 5, 5, 15, 15, 5);   want[2] = 2'd0;
    vecs[3] = fv(9, 0, 1, 0, 0, 0);     want[3] = 2'd1;
    vecs[4] = fv(10, 0, 2, 14, 15, 0);  want[4] = 2'd0;
    vecs[5] = fv(0, 0, 15, 15, 14, 0);  want[5] = 2'd2;
    vecs[6] = fv(0, 0, 15, 0, 0, 15);   want[6] = 2'd1;
    for (int i = 0; i < 7; i++) begin
      run_inference(4, vecs[i], want[i], 4, $sformatf("dot_v%0d", i));
      release_result(4, $sformatf("dot_v%0d", i));
    end
  endtask

  task automatic test_back_pressure();
    run_inference(4, fv(9, 0, 1, 0, 0, 0), 2'd1, 4, "hold_setup");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      iv[4]  = ~iv[4];
      in_vec = in_vec ^ {21{4'h5}};
      @(posedge clk);
      #1;
      n_checks++;
      if (ov[4] !== 1'b1 || wc[4] !== 2'd1 || ir[4] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got out_valid=%b w_class=%0d in_ready=%b want 1/1/0",
                 c, ov[4], wc[4], ir[4]);
      end
    end
    @(negedge clk);
    iv[4]   = 1'b1;
    ordy[4] = 1'b1;
    in_vec  = fv(4, 5, 2, 1, 1, 0);
    @(posedge clk);
    #1;
    ordy[4] = 1'b0;
    n_checks++;
    if (ir[4] !== 1'b1 || ov[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_no_accept: got in_ready=%b out_valid=%b want 1/0", ir[4], ov[4]);
    end
    run_inference(4, fv(4, 5, 2, 1, 1, 0), 2'd2, 4, "hold_next");
    release_result(4, "hold_next");
  endtask

  task automatic test_reset_mid_eval();
    @(negedge clk);
    in_vec = fv(3, 3, 3, 3, 3, 3);
    iv[0]  = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || g_dut[0].u_dut.vote_q[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_eval: got out_valid=%b in_ready=%b vote0=%0d want 0/1/0",
               ov[0], ir[0], g_dut[0].u_dut.vote_q[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_inference(0, fv(8, 8, 8, 8, 8, 8), 2'd0, 4, "post_reset");
    n_checks++;
    if (g_dut[0].u_dut.vote_q[0] !== 2'd2 || g_dut[0].u_dut.vote_q[1] !== 2'd1 ||
        g_dut[0].u_dut.vote_q[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset votes: got %0d,%0d,%0d want 2,1,0", g_dut[0].u_dut.vote_q[0],
               g_dut[0].u_dut.vote_q[1], g_dut[0].u_dut.vote_q[2]);
    end
    release_result(0, "post_reset");
  endtask

  task automatic test_reset_in_done();
    run_inference(1, fv(2, 2, 2, 2, 2, 2), 2'd2, 4, "done_setup");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || wc[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_in_done: got out_valid=%b in_ready=%b w_class=%0d want 0/1/0",
               ov[1], ir[1], wc[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_inference(1, fv(0, 0, 0, 0, 0, 0), 2'd2, 4, "after_done_reset");
    release_result(1, "after_done_reset");
  endtask

  initial begin
    test_reset();
    test_bias_pos();
    test_bias_neg();
    test_tie();
    test_four_class();
    test_dot_product();
    test_back_pressure();
    test_reset_mid_eval();
    test_reset_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ovo_svm_sequencer.md
OVO_SVM_SEQUENCER -- requirements
Module: ovo_svm_sequencer

Interface
REQ-001 SHALL have parameter N_CLASSES, default 3: number of classes, legal range 2..16.
REQ-002 SHALL have parameter N_FEATURES, default 21: input feature count.
REQ-003 SHALL have parameter INPUT_W, default 4: unsigned feature width.
REQ-004 SHALL have parameter WEIGHT_W, default 8: signed weight width.
REQ-005 SHALL have parameter BIAS_W, default 12: signed bias width.
REQ-006 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-008 SHALL have port in  in  INPUT_W*N_FEATURES: packed feature vector; feature 0 in the LSBs.
REQ-009 SHALL have port in_valid  in  1: a feature vector is offered.
REQ-010 SHALL have port in_ready  out  1: the block can accept a vector.
REQ-011 SHALL have port out_valid  out  1: w_class holds a result.
REQ-012 SHALL have port out_ready  in  1: the consumer takes the result.
REQ-013 SHALL have port w_class  out  CLS_W = max(1, clog2(N_CLASSES)): winning class index.

Function
REQ-014 SHALL evaluate P = N_CLASSES*(N_CLASSES-1)/2 one-vs-one classifiers, one per cycle, on a single shared evaluator.
REQ-015 SHALL order pairs (i,j), i<j, lexicographically: k=0 is (0,1), then (0,2), ..., with (N-2,N-1) last.
REQ-016 SHALL use FSM states IDLE, EVAL, ARGMAX and DONE; reset state is IDLE.
REQ-017 SHALL assert in_ready exactly when the FSM is in IDLE.
REQ-018 SHALL, on in_valid&&in_ready (the accept edge), register `in` into an internal feature latch, clear all vote counters, set pair index k=0 and go to EVAL.
REQ-019 SHALL, in EVAL, compute d = sum over f of (signed(W[k][f]) * zero-extended in[f]) + sign-extended B[k]. Accumulator width is INPUT_W+WEIGHT_W+clog2(N_FEATURES)+2; no saturation or truncation.
REQ-020 SHALL, in EVAL, increment vote[i] when d>=0 and vote[j] otherwise, then increment k.
REQ-021 SHALL leave EVAL for ARGMAX after the edge that processes pair P-1.
REQ-022 SHALL, in ARGMAX, register into w_class the class with the maximum vote count; on a tie the lowest class index wins. The FSM then goes to DONE.
REQ-023 SHALL assert out_valid only in DONE, so that out_valid rises exactly P+1 rising edges after the accept edge.
REQ-024 SHALL hold w_class and out_valid stable in DONE until out_ready is high, then return to IDLE on that edge.
REQ-025 SHALL ignore in_valid and changes on `in` outside IDLE; the latched features are used for the whole inference.
REQ-026 SHALL size each vote counter as clog2(N_CLASSES) bits, since the maximum count is N_CLASSES-1; the counters cannot wrap.
REQ-027 SHALL reach IDLE again in the same edge as out_ready, but SHALL NOT accept a new vector in that edge; the earliest accept is the following edge.

Reset
REQ-028 SHALL, while rst_n is low, force FSM=IDLE, k=0, all votes=0, w_class=0, out_valid=0 and in_ready=1 (asynchronously), regardless of the current state.
REQ-029 SHALL leave the feature latch unreset; it is don't-care until the first accept.
REQ-030 SHALL, after a reset asserted mid-EVAL or in DONE, discard the aborted inference; the next accept behaves as the first after power-up.

Structure
REQ-031 SHALL take the N_CLASSES-dependent widths, the pair-index-to-(i,j) lookup function and the per-dataset constant arrays W[P][N_FEATURES] and B[P] from shared package ovo_svm_pkg.
REQ-032 SHALL instantiate one sub-module, svm_pair_eval: a combinational dot product plus bias and sign, with inputs features, weights and bias, and output decision.

Verification
REQ-033 SHALL cover: N_CLASSES=3, all W=0, all B=+1 -> votes {2,1,0}, w_class=0, out_valid rises on the 4th edge after accept.
REQ-034 SHALL cover: N_CLASSES=3, all W=0, all B=-1 -> votes {0,1,2}, w_class=2.
REQ-035 SHALL cover: N_CLASSES=3, W=0, B={+1,-1,+1} -> one vote per class, tie, w_class=0.
REQ-036 SHALL cover: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and `in` -> w_class and out_valid stable, in_ready=0, no new accept; release out_ready -> IDLE, then accept on the next edge.
REQ-037 SHALL cover: rst_n pulsed low at the 2nd EVAL cycle -> out_valid=0 and in_ready=1 immediately; a following inference with B={+1,+1,+1} gives w_class=0 with correct latency.
REQ-038 SHALL cover: N_CLASSES=4, W=0, B=-1 for all six pairs -> votes {0,1,2,3}, w_class=3, out_valid rises on the 7th edge after accept.
